router_pkt_engine: RTL
======================

# router_pkt_engine

Parametrised packet register engine for the router input path. It accepts a byte-serial packet stream and decodes the header (destination, length). It then forwards header, payload and parity words to one of NUM_PORTS output FIFOs, parking a word locally when the target FIFO is full. It computes running parity and flags parity and length errors. It sits between the router input port and the per-port output FIFOs, and replaces the fixed 8-bit, 3-port register stage with its own sequencing FSM.

## Interface
Parameters:
- DATA_W, 8, data word width (≥ ADDR_W+1)
- NUM_PORTS, 3, output ports (≥2); ADDR_W = $clog2(NUM_PORTS)

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  high for header and payload words; low on parity word
- data_in  in  DATA_W  input word
- busy  out  1  high: source must hold data_in/pkt_valid stable
- fifo_full  in  NUM_PORTS  per-port full flags
- write_en  out  NUM_PORTS  one-hot FIFO write strobe (registered)
- dout  out  DATA_W  word to FIFO, valid with write_en
- low_pkt_valid  out  1  parity word accepted; cleared at next header
- parity_done  out  1  one-cycle pulse, parity compare complete
- err  out  1  parity mismatch, sticky until next header accepted
- len_err  out  1  payload count ≠ header length (macro-dependent)
- drop  out  1  one-cycle pulse, invalid-destination packet discarded

## Operation
- Header word: dest = data_in[ADDR_W-1:0], len = data_in[DATA_W-1:ADDR_W].
- A word is accepted on a rising edge with busy=0 and the FSM in IDLE with pkt_valid=1, LOAD, or DROP.
- int_parity = XOR of the header and all payload words, cleared on header accept.
- States:
  - IDLE: busy=0. On pkt_valid=1: latch header, clear err/len_err/low_pkt_valid, int_parity=data_in.
    - dest ≥ NUM_PORTS → DROP.
    - fifo_full[dest]=1 → HDR_WAIT; header parked.
    - otherwise write the header → LOAD.
  - HDR_WAIT: busy=1. When fifo_full[dest]=0, write the parked header → LOAD.
  - LOAD: busy=0.
    - pkt_valid=1 (payload): XOR into int_parity, increment count. fifo_full[dest]=1 → park word, go to HOLD; else write the word.
    - pkt_valid=0 (parity word): latch pkt_parity, set low_pkt_valid. fifo_full[dest]=1 → park the word with last flag set, go to HOLD; else write it → CHECK.
  - HOLD: busy=1, inputs ignored. When fifo_full[dest]=0, write the parked word; last flag set → CHECK, else → LOAD.
  - CHECK: busy=1 for one cycle.
    - parity_done=1; err = (pkt_parity ≠ int_parity).
    - len_err updated per Configuration.
    - → IDLE.
  - DROP: busy=0. Consume words with no writes. On pkt_valid=0, consume the parity word, pulse drop → IDLE.
- Only write_en[dest] ever asserts; at most one write per cycle.
- fifo_full bits for non-target ports are ignored.

## Timing
- Reset (resetn=0 at an edge) forces, regardless of state:
  - FSM to IDLE
  - busy, write_en, dout, low_pkt_valid, parity_done, err, len_err, drop to 0
  - all internal registers (parked word, counter, parities) to 0
- Write latency:
  - Word accepted at edge N with target not full → write_en/dout valid in the cycle after edge N.
  - From HOLD/HDR_WAIT: write occurs in the cycle after the edge that samples fifo_full[dest]=0.
- busy is registered: high in the cycle after entering HDR_WAIT, HOLD or CHECK.
- parity_done/err valid in the cycle after the parity word's write; err holds until the next header accept.
- Zero-length packet: header then parity word.
- Back-to-back packets: the next header may be presented in the cycle after CHECK (busy=0).
- fifo_full asserting on a word's accept edge → word parked, never lost or duplicated.
- pkt_valid/data_in changes while busy=1 → ignored.

## Configuration
- ROUTER_LEN_CHECK_EN defined:
  - count is an (DATA_W-ADDR_W)-bit payload counter; it wraps silently.
  - in CHECK, len_err = (count ≠ len).
  - DROP packets never set len_err.
- Undefined: counter absent, len_err tied 0.

## Test plan
- Defaults, header 8'h0D (dest 1, len 3), payload 11/22/33, parity 8'h0D, fifo_full=0 → write_en=3'b010 for 5 consecutive cycles with dout 0D,11,22,33,0D; parity_done pulse; err=0; len_err=0.
- Same packet, parity 8'h0C → err=1, held until next header accepted.
- fifo_full[1]=1 on the accept of 8'h22 for 4 cycles → busy=1, no writes; 8'h22 written once after release; stream order preserved.
- Header 8'h07 (dest 3) + 2 payload + parity → write_en never asserts; drop pulses once; FSM returns to IDLE.
- ROUTER_LEN_CHECK_EN, header 8'h0D with 2 payload words → len_err=1; without macro → len_err=0.
- resetn=0 mid-payload while in HOLD → all outputs 0; next packet processed normally.

Source files
------------

// File: rtl/router_pkt_engine.sv
// Byte-serial packet register engine: header decode, per-port FIFO writes, parity/length check.
// Optional payload length check is built when ROUTER_LEN_CHECK_EN is defined.
module router_pkt_engine #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic [NUM_PORTS-1:0] write_en,
  output logic [DATA_W-1:0]    dout,
  output logic                 low_pkt_valid,
  output logic                 parity_done,
  output logic                 err,
  output logic                 len_err,
  output logic                 drop
);

  localparam int ADDR_W = $clog2(NUM_PORTS);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] NP_W = (ADDR_W+1)'(NUM_PORTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_LOAD,
    S_HOLD,
    S_CHECK,
    S_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [NUM_PORTS-1:0]   we_q, we_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   lpv_q, lpv_d;
  logic                   pdone_q, pdone_d;
  logic                   err_q, err_d;
  logic                   drop_q, drop_d;
  logic [ADDR_W-1:0]      dest_q, dest_d;
  logic [DATA_W-1:0]      park_q, park_d;
  logic                   last_q, last_d;
  logic [DATA_W-1:0]      ipar_q, ipar_d;
  logic [DATA_W-1:0]      ppar_q, ppar_d;

  logic [ADDR_W-1:0]      hdr_dest;
  logic [NUM_PORTS-1:0]   hdr_oh;
  logic [NUM_PORTS-1:0]   tgt_oh;
  logic                   hdr_bad;
  logic                   hdr_full;
  logic                   tgt_full;

`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   len_err_q, len_err_d;
`endif

  assign hdr_dest = data_in[ADDR_W-1:0];
  assign hdr_oh   = NUM_PORTS'(1) << hdr_dest;
  assign tgt_oh   = NUM_PORTS'(1) << dest_q;
  assign hdr_bad  = {1'b0, hdr_dest} >= NP_W;
  assign hdr_full = |(fifo_full & hdr_oh);
  assign tgt_full = |(fifo_full & tgt_oh);

  always_comb begin
    state_d = state_q;
    we_d    = '0;
    dout_d  = dout_q;
    lpv_d   = lpv_q;
    pdone_d = 1'b0;
    err_d   = err_q;
    drop_d  = 1'b0;
    dest_d  = dest_q;
    park_d  = park_q;
    last_d  = last_q;
    ipar_d  = ipar_q;
    ppar_d  = ppar_q;
`ifdef ROUTER_LEN_CHECK_EN
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          dest_d = hdr_dest;
          err_d  = 1'b0;
          lpv_d  = 1'b0;
          ipar_d = data_in;
          last_d = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
          len_d     = data_in[DATA_W-1:ADDR_W];
          cnt_d     = '0;
          len_err_d = 1'b0;
`endif
          if (hdr_bad) begin
            state_d = S_DROP;
          end else if (hdr_full) begin
            park_d  = data_in;
            state_d = S_HDR_WAIT;
          end else begin
            we_d    = hdr_oh;
            dout_d  = data_in;
            state_d = S_LOAD;
          end
        end
      end
      S_HDR_WAIT, S_HOLD: begin
        if (!tgt_full) begin
          we_d    = tgt_oh;
          dout_d  = park_q;
          state_d = last_q ? S_CHECK : S_LOAD;
        end
      end
      S_LOAD: begin
        if (pkt_valid) begin
          ipar_d = ipar_q ^ data_in;
          last_d = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
          cnt_d  = cnt_q + 1'b1;
`endif
        end else begin
          ppar_d = data_in;
          lpv_d  = 1'b1;
          last_d = 1'b1;
        end
        // A full target parks the word; HOLD replays it once space frees up.
        if (tgt_full) begin
          park_d  = data_in;
          state_d = S_HOLD;
        end else begin
          we_d    = tgt_oh;
          dout_d  = data_in;
          state_d = pkt_valid ? S_LOAD : S_CHECK;
        end
      end
      S_CHECK: begin
        pdone_d = 1'b1;
        err_d   = (ppar_q != ipar_q);
`ifdef ROUTER_LEN_CHECK_EN
        len_err_d = (cnt_q != len_q);
`endif
        state_d = S_IDLE;
      end
      S_DROP: begin
        if (!pkt_valid) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_HDR_WAIT) ||
             (state_d == S_HOLD) ||
             (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      we_q    <= '0;
      dout_q  <= '0;
      lpv_q   <= 1'b0;
      pdone_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      dest_q  <= '0;
      park_q  <= '0;
      last_q  <= 1'b0;
      ipar_q  <= '0;
      ppar_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      lpv_q   <= lpv_d;
      pdone_q <= pdone_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      dest_q  <= dest_d;
      park_q  <= park_d;
      last_q  <= last_d;
      ipar_q  <= ipar_d;
      ppar_q  <= ppar_d;
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  assign busy          = busy_q;
  assign write_en      = we_q;
  assign dout          = dout_q;
  assign low_pkt_valid = lpv_q;
  assign parity_done   = pdone_q;
  assign err           = err_q;
  assign drop          = drop_q;

endmodule
